// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and busy scoreboard
//
// Purpose:
//   General register file for the MiniMIPS32 pipeline. NUM_RD combinational
//   read ports, two synchronous write ports (wb0 main, wb1 late writeback with
//   priority), write-to-read bypass on every read port, and a per-register busy
//   scoreboard set at issue and cleared at commit.
//
// Ports:
//   cpu_clk_50M  in   clock, rising edge
//   cpu_rst_n    in   asynchronous active-low reset
//   we0/wa0/wd0  in   write port 0
//   we1/wa1/wd1  in   write port 1 (wins on address collision)
//   ra           in   packed read addresses, port k = ra[k*ADDR_W +: ADDR_W]
//   rd           out  packed read data,      port k = rd[k*DATA_W +: DATA_W]
//   rbusy        out  per read port: source still has an uncommitted producer
//   sb_set       in   mark sb_addr busy (issue)
//   sb_addr      in   destination register of the issued instruction
//   sb_flush     in   clear every busy bit
//   any_busy     out  OR of all registered busy bits

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       cpu_clk_50M,
    input  logic                       cpu_rst_n,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       sb_set,
    input  logic [ADDR_W-1:0]          sb_addr,
    input  logic                       sb_flush,
    output logic                       any_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // A write "hits" only when it targets a real register; writes to a
    // hardwired r0 are dropped everywhere (storage, bypass, scoreboard).
    logic hit0_en;
    logic hit1_en;
    logic set_en;

    assign hit0_en = we0    && !((ZERO_REG != 0) && (wa0 == '0));
    assign hit1_en = we1    && !((ZERO_REG != 0) && (wa1 == '0));
    assign set_en  = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

    // Register storage. Port 1 is written last so it overrides port 0 when
    // both target the same address.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (hit0_en) begin
                regs[wa0] <= wd0;
            end
            if (hit1_en) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Scoreboard next state. Set beats commit: the set belongs to a younger
    // producer issued after the one now committing.
    always_comb begin
        busy_nxt = busy;
        if (sb_flush) begin
            busy_nxt = '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (set_en && (sb_addr == ADDR_W'(a))) begin
                    busy_nxt[a] = 1'b1;
                end else if ((hit0_en && (wa0 == ADDR_W'(a))) ||
                             (hit1_en && (wa1 == ADDR_W'(a)))) begin
                    busy_nxt[a] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Outputs are forced low while reset is held, even though the bypass
    // path would otherwise pass live write data straight through.
    assign any_busy = cpu_rst_n && (|busy);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;
        logic              p0_hit;
        logic              p1_hit;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr     = ra[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        assign p0_hit   = hit0_en && (wa0 == addr);
        assign p1_hit   = hit1_en && (wa1 == addr);

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (cpu_rst_n && !zero_hit) begin
                if (p1_hit) begin
                    data = wd1;
                end else if (p0_hit) begin
                    data = wd0;
                end else begin
                    data = regs[addr];
                end
                // A same-cycle commit to the source satisfies the read via bypass.
                bsy = busy[addr] && !(p0_hit || p1_hit);
            end
        end

        assign rd[k*DATA_W +: DATA_W] = data;
        assign rbusy[k]               = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp

module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             cpu_clk_50M;
    logic             cpu_rst_n;
    logic             we0, we1;
    logic [AW-1:0]    wa0, wa1;
    logic [DW-1:0]    wd0, wd1;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             sb_flush;
    logic             any_busy;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .cpu_clk_50M(cpu_clk_50M),
        .cpu_rst_n  (cpu_rst_n),
        .we0        (we0),
        .wa0        (wa0),
        .wd0        (wd0),
        .we1        (we1),
        .wa1        (wa1),
        .wd1        (wd1),
        .ra         (ra),
        .rd         (rd),
        .rbusy      (rbusy),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .sb_flush   (sb_flush),
        .any_busy   (any_busy)
    );

    initial cpu_clk_50M = 1'b0;
    always #10 cpu_clk_50M = ~cpu_clk_50M;

    // kind: 0 = rd[port], 1 = rbusy[port], 2 = any_busy
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 0;

    task automatic expect_val(input string n, input int kind, input int port, input logic [31:0] v);
        chk_t c;
        c.name = n;
        c.kind = kind;
        c.port = port;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic exp_rd(input string n, input int p, input logic [31:0] v);
        expect_val(n, 0, p, v);
    endtask

    task automatic exp_rb(input string n, input int p, input logic v);
        expect_val(n, 1, p, {31'b0, v});
    endtask

    task automatic exp_any(input string n, input logic v);
        expect_val(n, 2, 0, {31'b0, v});
    endtask

    // Monitor: outputs are combinational, so every queued expectation is
    // compared at the falling edge of the cycle in which it was issued.
    always @(negedge cpu_clk_50M) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = q.pop_front();
            case (c.kind)
                0:       act = rd[c.port*DW +: DW];
                1:       act = {31'b0, rbusy[c.port]};
                default: act = {31'b0, any_busy};
            endcase
            checks++;
            if (act !== c.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
            end
        end
    end

    task automatic idle();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        sb_set = 0; sb_addr = '0; sb_flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge cpu_clk_50M);
        #1;
        idle();
    endtask

    function automatic logic [NR*AW-1:0] rda(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        return {a1, a0};
    endfunction

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        cpu_rst_n = 0;
        idle();
        ra = rda(5'd5, 5'd5);

        // Reset held: outputs low even with an active bypass write.
        @(posedge cpu_clk_50M); #1;
        we1 = 1; wa1 = 5'd5; wd1 = 32'h12345678; sb_set = 1; sb_addr = 5'd5;
        exp_rd("rst_rd_bypass", 0, 32'h0);
        exp_rb("rst_rbusy", 0, 1'b0);
        exp_any("rst_any", 1'b0);
        next_cycle();
        cpu_rst_n = 1;

        // Write r5 and mark busy; verify, then reset mid-cycle.
        next_cycle();
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; sb_set = 1; sb_addr = 5'd5;
        next_cycle();
        ra = rda(5'd5, 5'd0);
        exp_rd("r5_stored", 0, 32'hDEADBEEF);
        exp_rb("r5_busy", 0, 1'b1);
        exp_any("r5_any", 1'b1);
        next_cycle();
        cpu_rst_n = 0;
        exp_rd("r5_rst_now", 0, 32'h0);
        exp_any("r5_rst_any", 1'b0);
        next_cycle();
        cpu_rst_n = 1;
        exp_rd("r5_after_rst", 0, 32'h0);
        exp_rb("r5_after_rst_busy", 0, 1'b0);
        exp_any("after_rst_any", 1'b0);

        // Dual-write collision on r7.
        next_cycle();
        we0 = 1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1; wa1 = 5'd7; wd1 = 32'h22222222;
        ra = rda(5'd7, 5'd7);
        exp_rd("coll_byp_p0", 0, 32'h22222222);
        exp_rd("coll_byp_p1", 1, 32'h22222222);
        next_cycle();
        exp_rd("coll_stored", 0, 32'h22222222);

        // Bypass over stored value on both ports.
        next_cycle();
        we1 = 1; wa1 = 5'd3; wd1 = 32'hA5A5A5A5;
        next_cycle();
        ra = rda(5'd3, 5'd7);
        exp_rd("r3_stored", 0, 32'hA5A5A5A5);
        next_cycle();
        we0 = 1; wa0 = 5'd3; wd0 = 32'h5A5A5A5A;
        ra = rda(5'd3, 5'd3);
        exp_rd("byp_p0", 0, 32'h5A5A5A5A);
        exp_rd("byp_p1", 1, 32'h5A5A5A5A);
        next_cycle();
        exp_rd("byp_stored", 1, 32'h5A5A5A5A);

        // Zero register ignores writes and scoreboard.
        next_cycle();
        we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; sb_set = 1; sb_addr = 5'd0;
        ra = rda(5'd0, 5'd0);
        exp_rd("r0_byp", 0, 32'h0);
        exp_rb("r0_rbusy", 1, 1'b0);
        exp_any("r0_any", 1'b0);
        next_cycle();
        exp_rd("r0_stored", 1, 32'h0);
        exp_rb("r0_rbusy_next", 0, 1'b0);
        exp_any("r0_any_next", 1'b0);

        // Scoreboard on r9.
        next_cycle();
        sb_set = 1; sb_addr = 5'd9;
        ra = rda(5'd9, 5'd9);
        exp_rb("sb_c0", 0, 1'b0);
        exp_any("sb_c0_any", 1'b0);
        next_cycle();
        exp_rb("sb_c1", 0, 1'b1);
        exp_any("sb_c1_any", 1'b1);
        next_cycle();
        exp_rb("sb_c2", 1, 1'b1);
        next_cycle();
        we0 = 1; wa0 = 5'd9; wd0 = 32'h00C0FFEE;
        exp_rb("sb_c3_byp", 0, 1'b0);
        exp_rd("sb_c3_rd", 0, 32'h00C0FFEE);
        exp_any("sb_c3_any", 1'b1);
        next_cycle();
        exp_rb("sb_c4", 0, 1'b0);
        exp_any("sb_c4_any", 1'b0);
        next_cycle();
        sb_set = 1; sb_addr = 5'd9;
        we1 = 1; wa1 = 5'd9; wd1 = 32'h00000099;
        exp_rb("setcommit_now", 0, 1'b0);
        next_cycle();
        exp_rb("setcommit_p0", 0, 1'b1);
        exp_rb("setcommit_p1", 1, 1'b1);
        exp_any("setcommit_any", 1'b1);

        // Flush overrides a same-cycle set.
        next_cycle();
        sb_set = 1; sb_addr = 5'd2;
        next_cycle();
        sb_set = 1; sb_addr = 5'd4;
        next_cycle();
        sb_set = 1; sb_addr = 5'd31;
        next_cycle();
        ra = rda(5'd2, 5'd31);
        exp_rb("fl_r2", 0, 1'b1);
        exp_rb("fl_r31", 1, 1'b1);
        next_cycle();
        sb_flush = 1; sb_set = 1; sb_addr = 5'd6;
        ra = rda(5'd6, 5'd4);
        exp_rb("fl_now_r6", 0, 1'b0);
        exp_rb("fl_now_r4", 1, 1'b1);
        exp_any("fl_now_any", 1'b1);
        next_cycle();
        ra = rda(5'd6, 5'd2);
        exp_rb("fl_after_r6", 0, 1'b0);
        exp_rb("fl_after_r2", 1, 1'b0);
        exp_any("fl_after_any", 1'b0);

        next_cycle();
        @(posedge cpu_clk_50M);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d expected 0", q.size());
        end
        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
